// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared constants, engine state encoding and parity helper for the UART transmit path
package uart_pkg;

  localparam int PAR_NONE      = 0;
  localparam int PAR_ODD       = 1;
  localparam int PAR_EVEN      = 2;
  localparam int MAX_DATA_BITS = 9;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP
  } tx_state_t;

  // Zero padding above the real word width leaves the XOR reduction unchanged.
  function automatic logic parity_bit(input logic [MAX_DATA_BITS-1:0] data, input int mode);
    logic p;
    p = 1'b0;
    if (mode == PAR_ODD)
      p = ~^data;
    else if (mode == PAR_EVEN)
      p = ^data;
    return p;
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// rtl/uart_baud_tick.sv - bit-period strobe generator, held at zero while idle and restarted on frame load
module uart_baud_tick #(
  parameter int CLKS_PER_BIT = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic restart,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

  logic [CW-1:0] cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (!enable || restart || (cnt == LAST))
      cnt <= '0;
    else
      cnt <= cnt + 1'b1;
  end

  // With one clock per bit the counter is pinned at zero, so this strobes every cycle.
  assign tick = (cnt == LAST);

endmodule

// File: rtl/uart_tx_framer.sv
// rtl/uart_tx_framer.sv - UART transmit framer with valid/ready intake and a one-word hold register
module uart_tx_framer #(
  parameter int DATA_BITS    = 8,
  parameter int CLKS_PER_BIT = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                 Clk,
  input  logic                 Reset,
  input  logic [DATA_BITS-1:0] DataIn,
  input  logic                 Valid,
  output logic                 Ready,
  output logic                 TxOut,
  output logic                 Busy,
  output logic                 Empty
);

  import uart_pkg::*;

  localparam int BCW = $clog2(DATA_BITS + 1);
  localparam logic [BCW-1:0] LAST_DATA = BCW'(DATA_BITS - 1);
  localparam logic [BCW-1:0] LAST_STOP = BCW'(STOP_BITS - 1);

  tx_state_t            state, state_next;
  logic [DATA_BITS-1:0] shift, shift_next, hold_data, word;
  logic                 par_bit, par_next;
  logic [BCW-1:0]       bit_cnt, bit_cnt_next;
  logic                 hold_full, hold_full_next;
  logic                 tick, accept, frame_end, load_new, load_hold, capture, tx_next;

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk    (Clk),
    .rst_n  (Reset),
    .enable (state != ST_IDLE),
    .restart(load_new || load_hold),
    .tick   (tick)
  );

  always_comb begin
    accept    = Valid && !hold_full;
    frame_end = (state == ST_STOP) && tick && (bit_cnt == LAST_STOP);
    load_hold = frame_end && hold_full;
    // accept implies hold is empty, so at frame end the new word bypasses hold
    load_new  = accept && ((state == ST_IDLE) || frame_end);
    capture   = accept && !load_new;

    hold_full_next = hold_full;
    if (load_hold)
      hold_full_next = 1'b0;
    else if (capture)
      hold_full_next = 1'b1;

    state_next   = state;
    shift_next   = shift;
    par_next     = par_bit;
    bit_cnt_next = bit_cnt;
    word         = load_hold ? hold_data : DataIn;

    case (state)
      ST_IDLE: ;
      ST_START:
        if (tick) begin
          state_next   = ST_DATA;
          bit_cnt_next = '0;
        end
      ST_DATA:
        if (tick) begin
          shift_next = shift >> 1;
          if (bit_cnt == LAST_DATA) begin
            bit_cnt_next = '0;
            state_next   = (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
          end else begin
            bit_cnt_next = bit_cnt + 1'b1;
          end
        end
      ST_PARITY:
        if (tick) begin
          state_next   = ST_STOP;
          bit_cnt_next = '0;
        end
      ST_STOP:
        if (tick) begin
          if (bit_cnt == LAST_STOP)
            state_next = ST_IDLE;
          else
            bit_cnt_next = bit_cnt + 1'b1;
        end
      default: state_next = ST_IDLE;
    endcase

    if (load_new || load_hold) begin
      state_next   = ST_START;
      shift_next   = word;
      par_next     = parity_bit(MAX_DATA_BITS'(word), PARITY);
      bit_cnt_next = '0;
    end

    // Line level is derived from the next state so TxOut can stay a plain register.
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
      ST_PARITY: tx_next = par_next;
      default:   tx_next = 1'b1;
    endcase
  end

  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      state     <= ST_IDLE;
      shift     <= '0;
      par_bit   <= 1'b0;
      bit_cnt   <= '0;
      hold_full <= 1'b0;
      hold_data <= '0;
      TxOut     <= 1'b1;
    end else begin
      state     <= state_next;
      shift     <= shift_next;
      par_bit   <= par_next;
      bit_cnt   <= bit_cnt_next;
      hold_full <= hold_full_next;
      if (capture)
        hold_data <= DataIn;
      TxOut     <= tx_next;
    end
  end

  assign Ready = !hold_full;
  assign Busy  = (state != ST_IDLE);
  assign Empty = (state == ST_IDLE) && !hold_full;

endmodule

// File: tb/tb_uart_tx_framer.sv
// tb/tb_uart_tx_framer.sv - scoreboard bench decoding TxOut of three framer configurations cycle by cycle
module tb_uart_tx_framer;

  typedef struct {
    string bits;
    bit    b2b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  exp_t q0[$], q1[$], q2[$];

  logic       rst_a, valid_a, ready_a, tx_a, busy_a, empty_a;
  logic [7:0] data_a;
  logic       rst_b, valid_b, ready_b, tx_b, busy_b, empty_b;
  logic [7:0] data_b;
  logic       rst_c, valid_c, ready_c, tx_c, busy_c, empty_c;
  logic [6:0] data_c;

  uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(1), .PARITY(0), .STOP_BITS(1)) dut_a (
    .Clk(clk), .Reset(rst_a), .DataIn(data_a), .Valid(valid_a),
    .Ready(ready_a), .TxOut(tx_a), .Busy(busy_a), .Empty(empty_a));

  uart_tx_framer #(.DATA_BITS(8), .CLKS_PER_BIT(4), .PARITY(2), .STOP_BITS(1)) dut_b (
    .Clk(clk), .Reset(rst_b), .DataIn(data_b), .Valid(valid_b),
    .Ready(ready_b), .TxOut(tx_b), .Busy(busy_b), .Empty(empty_b));

  uart_tx_framer #(.DATA_BITS(7), .CLKS_PER_BIT(1), .PARITY(1), .STOP_BITS(2)) dut_c (
    .Clk(clk), .Reset(rst_c), .DataIn(data_c), .Valid(valid_c),
    .Ready(ready_c), .TxOut(tx_c), .Busy(busy_c), .Empty(empty_c));

  int         cpb_of[3] = '{1, 4, 1};
  int         flen[3]   = '{10, 44, 11};
  int         mon_cnt[3];
  logic [63:0] cap[3];
  int         start_cyc[3];
  int         last_end[3];
  int         cyc;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    tests++;
    if (act !== want) begin
      fails++;
      $display("FAIL %s: got %0h, want %0h", name, act, want);
    end
  endtask

  function automatic bit pop_exp(input int i, output exp_t e);
    bit got;
    got    = 1'b0;
    e.bits = "";
    e.b2b  = 1'b0;
    case (i)
      0: if (q0.size() > 0) begin e = q0.pop_front(); got = 1'b1; end
      1: if (q1.size() > 0) begin e = q1.pop_front(); got = 1'b1; end
      default: if (q2.size() > 0) begin e = q2.pop_front(); got = 1'b1; end
    endcase
    return got;
  endfunction

  task automatic check_frame(input int i);
    exp_t  e;
    string act, want;
    bit    ok;
    act  = "";
    want = "";
    ok   = 1'b1;
    tests++;
    if (!pop_exp(i, e)) begin
      fails++;
      $display("FAIL frame%0d_unexpected: got a frame, want none", i);
      return;
    end
    for (int c = 0; c < flen[i]; c++) begin
      bit w;
      w    = (e.bits[c / cpb_of[i]] == "1");
      act  = $sformatf("%s%0d", act, cap[i][c]);
      want = $sformatf("%s%0d", want, w);
      if (cap[i][c] !== w) ok = 1'b0;
    end
    if (!ok) begin
      fails++;
      $display("FAIL frame%0d_bits: got %s, want %s", i, act, want);
    end
    if (e.b2b) begin
      tests++;
      if (start_cyc[i] != last_end[i] + 1) begin
        fails++;
        $display("FAIL frame%0d_gap: got start cycle %0d, want %0d", i, start_cyc[i], last_end[i] + 1);
      end
    end
  endtask

  // Monitor: captures each frame from its start bit and compares it with the scoreboard head.
  initial begin
    logic t, r;
    cyc = 0;
    for (int i = 0; i < 3; i++) begin
      mon_cnt[i]   = 0;
      cap[i]       = '0;
      start_cyc[i] = 0;
      last_end[i]  = -10;
    end
    forever begin
      @(negedge clk);
      cyc++;
      for (int i = 0; i < 3; i++) begin
        t = (i == 0) ? tx_a : (i == 1) ? tx_b : tx_c;
        r = (i == 0) ? rst_a : (i == 1) ? rst_b : rst_c;
        if (!r) begin
          mon_cnt[i] = 0;
        end else if (mon_cnt[i] == 0) begin
          if (t == 1'b0) begin
            start_cyc[i] = cyc;
            cap[i]       = '0;
            mon_cnt[i]   = 1;
          end
        end else begin
          cap[i][mon_cnt[i]] = t;
          mon_cnt[i]++;
          if (mon_cnt[i] == flen[i]) begin
            check_frame(i);
            mon_cnt[i]  = 0;
            last_end[i] = cyc;
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0] vals[12];
    int n;
    vals = '{8'h01, 8'h80, 8'hFF, 8'h00, 8'h5A, 8'hA5, 8'h0F, 8'hF0, 8'h33, 8'hCC, 8'h99, 8'hC3};
    rst_a = 0; rst_b = 0; rst_c = 0;
    valid_a = 0; valid_b = 0; valid_c = 0;
    data_a = '0; data_b = '0; data_c = '0;
    repeat (3) step();
    check("rst_tx_a", tx_a, 1);
    check("rst_busy_a", busy_a, 0);
    check("rst_empty_a", empty_a, 1);
    check("rst_ready_a", ready_a, 1);
    check("rst_tx_b", tx_b, 1);
    check("rst_empty_c", empty_c, 1);
    rst_a = 1; rst_b = 1; rst_c = 1;
    step();

    // single word A5
    data_a = 8'hA5; valid_a = 1;
    q0.push_back('{"0101001011", 1'b0});
    step();
    valid_a = 0;
    check("a5_busy_k", busy_a, 1);
    repeat (9) step();
    check("a5_busy_k9", busy_a, 1);
    check("a5_empty_k9", empty_a, 0);
    step();
    check("a5_busy_k10", busy_a, 0);
    check("a5_empty_k10", empty_a, 1);
    step();

    // word offered on the last stop cycle loads straight into the engine
    data_a = 8'hA5; valid_a = 1;
    q0.push_back('{"0101001011", 1'b0});
    step();
    valid_a = 0;
    repeat (9) step();
    data_a = 8'h3C; valid_a = 1;
    q0.push_back('{"0001111001", 1'b1});
    step();
    valid_a = 0;
    check("direct_ready", ready_a, 1);
    check("direct_busy", busy_a, 1);
    repeat (10) step();
    check("direct_empty", empty_a, 1);
    step();

    // 55 then AA with Valid held
    data_a = 8'h55; valid_a = 1;
    q0.push_back('{"0101010101", 1'b0});
    step();
    check("b2b_ready_k", ready_a, 1);
    data_a = 8'hAA;
    q0.push_back('{"0010101011", 1'b1});
    step();
    valid_a = 0;
    check("b2b_ready_k1", ready_a, 0);
    repeat (8) step();
    check("b2b_ready_k9", ready_a, 0);
    step();
    check("b2b_ready_k10", ready_a, 1);
    check("b2b_busy_k10", busy_a, 1);
    repeat (10) step();
    check("b2b_empty", empty_a, 1);
    step();

    // DataIn changing every cycle while Valid stays high
    q0.push_back('{"0100000001", 1'b0});
    q0.push_back('{"0000000011", 1'b1});
    q0.push_back('{"0110000111", 1'b1});
    for (int j = 0; j < 12; j++) begin
      data_a = vals[j]; valid_a = 1;
      step();
      if (j == 1) check("chg_ready_k1", ready_a, 0);
      if (j == 10) check("chg_ready_k10", ready_a, 1);
      if (j == 11) check("chg_ready_k11", ready_a, 0);
    end
    valid_a = 0;
    repeat (19) step();
    check("chg_empty", empty_a, 1);
    step();

    // reset during data bit 3 with a word held
    data_a = 8'hF0; valid_a = 1;
    step();
    data_a = 8'h0F;
    step();
    valid_a = 0;
    check("rstmid_ready_held", ready_a, 0);
    repeat (3) step();
    rst_a = 0;
    #1;
    check("rstmid_tx", tx_a, 1);
    check("rstmid_ready", ready_a, 1);
    check("rstmid_empty", empty_a, 1);
    check("rstmid_busy", busy_a, 0);
    step();
    rst_a = 1;
    for (int j = 0; j < 15; j++) begin
      step();
      check("rstmid_line_idle", tx_a, 1);
    end
    data_a = 8'h3C; valid_a = 1;
    q0.push_back('{"0001111001", 1'b0});
    step();
    valid_a = 0;
    repeat (10) step();
    check("post_rst_empty", empty_a, 1);

    // even parity, four clocks per bit
    data_b = 8'h07; valid_b = 1;
    q1.push_back('{"01110000011", 1'b0});
    step();
    valid_b = 0;
    repeat (43) step();
    check("par_empty_k43", empty_b, 0);
    check("par_busy_k43", busy_b, 1);
    step();
    check("par_empty_k44", empty_b, 1);
    check("par_busy_k44", busy_b, 0);

    // seven bits, odd parity, two stop bits
    data_c = 7'h00; valid_c = 1;
    q2.push_back('{"00000000111", 1'b0});
    step();
    valid_c = 0;
    repeat (10) step();
    check("c_busy_k10", busy_c, 1);
    step();
    check("c_busy_k11", busy_c, 0);
    check("c_empty_k11", empty_c, 1);

    n = 0;
    while ((q0.size() + q1.size() + q2.size()) != 0 && n < 200) begin
      step();
      n++;
    end
    check("scoreboard_drained", q0.size() + q1.size() + q2.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, want finish");
    $fatal(1, "watchdog expired");
  end

endmodule
